// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : SRAM-like instruction port (addr_ok / data_ok handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS instruction fetch with a small instruction queue, single
//            outstanding request, delay-slot branch redirect and flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          QDEPTH   = 2
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  fetch_stage_if.master    imem,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  input  wire logic        id_allowin,
  input  wire logic        br_valid,
  input  wire logic [31:0] br_pc,
  input  wire logic [31:0] br_target,
  input  wire logic        flush,
  input  wire logic [31:0] flush_target
);

  localparam int                 c_ptr_w  = $clog2(QDEPTH);
  localparam int                 c_cnt_w  = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_qdepth = c_cnt_w'(QDEPTH);

  logic [31:0]        pc_q, pc_d;
  logic               out_q, out_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic [1:0]         disc_q, disc_d;
  logic               redir_q, redir_d;
  logic [31:0]        redir_tgt_q, redir_tgt_d;
  logic               stall_q, stall_d;
  logic [c_ptr_w-1:0] hd_q, hd_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [31:0]        qpc_q   [QDEPTH];
  logic [31:0]        qpc_d   [QDEPTH];
  logic [31:0]        qinst_q [QDEPTH];
  logic [31:0]        qinst_d [QDEPTH];

  logic               w_can_issue;
  logic               w_req;
  logic               w_misalign;
  logic               w_accept;
  logic               w_resp;
  logic               w_pop;
  logic               w_br;
  logic [31:0]        w_ds;
  logic               w_hit_q;
  logic               w_hit_out;
  logic [c_cnt_w-1:0] w_keep_cnt;
  logic [c_cnt_w-1:0] w_cnt;
  logic               w_push;
  logic [31:0]        w_push_pc;
  logic [31:0]        w_push_inst;
  logic               w_pop_eff;
  logic [c_ptr_w-1:0] w_wr_idx;

  // Misaligned PCs never reach the port; they become an error entry instead.
  assign w_can_issue   = resetn && !out_q && (cnt_q < c_qdepth) && !stall_q;
  assign w_req         = w_can_issue && (pc_q[1:0] == 2'b00);
  assign w_misalign    = w_can_issue && (pc_q[1:0] != 2'b00);
  assign w_accept      = w_req && imem.inst_addr_ok;
  assign w_resp        = out_q && imem.inst_data_ok;
  assign imem.inst_req  = w_req;
  assign imem.inst_addr = pc_q;

  assign if_valid = (cnt_q != '0);
  assign if_pc    = if_valid ? qpc_q[hd_q]   : 32'd0;
  assign if_inst  = if_valid ? qinst_q[hd_q] : 32'd0;
  assign w_pop    = if_valid && id_allowin;
  assign w_br     = br_valid && !flush;

  // Delay-slot search, oldest queue entry first, then the in-flight request.
  always_comb begin
    w_ds       = br_pc + 32'd4;
    w_hit_q    = 1'b0;
    w_keep_cnt = cnt_q;
    for (int i = QDEPTH - 1; i >= 0; i--) begin
      if ((c_cnt_w'(i) < cnt_q) && (qpc_q[hd_q + c_ptr_w'(i)] == w_ds)) begin
        w_hit_q    = 1'b1;
        w_keep_cnt = c_cnt_w'(i + 1);
      end
    end
    w_hit_out = !w_hit_q && out_q && (disc_q == 2'd0) && (out_pc_q == w_ds);
  end

  always_comb begin
    pc_d        = pc_q;
    out_d       = out_q;
    out_pc_d    = out_pc_q;
    disc_d      = disc_q;
    redir_d     = redir_q;
    redir_tgt_d = redir_tgt_q;
    stall_d     = stall_q;
    hd_d        = hd_q;
    qpc_d       = qpc_q;
    qinst_d     = qinst_q;
    w_cnt       = cnt_q;
    w_push      = 1'b0;
    w_push_pc   = out_pc_q;
    w_push_inst = imem.inst_rdata;
    w_pop_eff   = w_pop;
    w_wr_idx    = '0;

    if (w_accept) begin
      out_d    = 1'b1;
      out_pc_d = pc_q;
      pc_d     = redir_q ? redir_tgt_q : pc_q + 32'd4;
      redir_d  = 1'b0;
    end

    if (w_resp) begin
      out_d = 1'b0;
      if (disc_q != 2'd0) begin
        disc_d = disc_q - 2'd1;
      end else begin
        w_push = 1'b1;
      end
    end

    if (w_misalign) begin
      w_push      = 1'b1;
      w_push_pc   = pc_q;
      w_push_inst = 32'd0;
      stall_d     = 1'b1;
    end

    if (w_br) begin
      if (w_hit_q) begin
        // Everything younger than the queued delay slot is wrong-path.
        w_cnt   = w_keep_cnt;
        w_push  = 1'b0;
        stall_d = stall_q;
        if ((out_q && !w_resp) || w_accept) begin
          disc_d = 2'd1;
        end
        pc_d    = br_target;
        redir_d = 1'b0;
      end else if (w_hit_out || (w_accept && (pc_q == w_ds))) begin
        pc_d    = br_target;
        redir_d = 1'b0;
      end else begin
        redir_d     = 1'b1;
        redir_tgt_d = br_target;
      end
    end

    if (flush) begin
      w_cnt     = '0;
      w_push    = 1'b0;
      w_pop_eff = 1'b0;
      disc_d    = ((out_q && !w_resp) || w_accept) ? 2'd1 : 2'd0;
      redir_d   = 1'b0;
      stall_d   = 1'b0;
      pc_d      = flush_target;
    end

    w_wr_idx = hd_q + w_cnt[c_ptr_w-1:0];
    if (w_push) begin
      qpc_d[w_wr_idx]   = w_push_pc;
      qinst_d[w_wr_idx] = w_push_inst;
    end
    if (w_pop_eff) begin
      hd_d = hd_q + c_ptr_w'(1);
    end
    cnt_d = w_cnt - c_cnt_w'(w_pop_eff) + c_cnt_w'(w_push);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q        <= RESET_PC;
      out_q       <= 1'b0;
      out_pc_q    <= 32'd0;
      disc_q      <= 2'd0;
      redir_q     <= 1'b0;
      redir_tgt_q <= 32'd0;
      stall_q     <= 1'b0;
      hd_q        <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qpc_q[i]   <= 32'd0;
        qinst_q[i] <= 32'd0;
      end
    end else begin
      pc_q        <= pc_d;
      out_q       <= out_d;
      out_pc_q    <= out_pc_d;
      disc_q      <= disc_d;
      redir_q     <= redir_d;
      redir_tgt_q <= redir_tgt_d;
      stall_q     <= stall_d;
      hd_q        <= hd_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < QDEPTH; i++) begin
        qpc_q[i]   <= qpc_d[i];
        qinst_q[i] <= qinst_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed bench for fetch_stage with a small instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_allowin = 1'b1;
  logic        br_valid = 1'b0;
  logic [31:0] br_pc = 32'd0;
  logic [31:0] br_target = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] flush_target = 32'd0;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mem_delay = 1;
  logic [31:0] pop_log[$];
  logic [31:0] iss_log[$];

  fetch_stage_if u_if ();

  fetch_stage #(
    .RESET_PC (32'hBFC0_0000),
    .QDEPTH   (2)
  ) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .imem         (u_if),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .id_allowin   (id_allowin),
    .br_valid     (br_valid),
    .br_pc        (br_pc),
    .br_target    (br_target),
    .flush        (flush),
    .flush_target (flush_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int count_in(input logic [31:0] q[$], input logic [31:0] v);
    int n = 0;
    foreach (q[i]) if (q[i] == v) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: accepts every request, answers mem_delay cycles later.
  initial begin : p_mem
    logic        pend;
    logic [31:0] addr;
    int          wait_n;
    pend = 1'b0;
    addr = 32'd0;
    wait_n = 0;
    u_if.inst_addr_ok = 1'b1;
    u_if.inst_data_ok = 1'b0;
    u_if.inst_rdata   = 32'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pend = 1'b0;
      end else if (u_if.inst_req && u_if.inst_addr_ok) begin
        pend   = 1'b1;
        addr   = u_if.inst_addr;
        wait_n = mem_delay;
      end
      @(posedge clk);
      #1;
      u_if.inst_data_ok = 1'b0;
      if (pend) begin
        wait_n--;
        if (wait_n == 0) begin
          u_if.inst_data_ok = 1'b1;
          u_if.inst_rdata   = mem_word(addr);
          pend = 1'b0;
        end
      end
    end
  end

  // Decode-side and port-side logging; every delivered word is checked.
  initial begin : p_mon
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (u_if.inst_req && u_if.inst_addr_ok) iss_log.push_back(u_if.inst_addr);
        if (if_valid && id_allowin) begin
          pop_log.push_back(if_pc);
          chk("pop_inst", if_inst, (if_pc[1:0] != 2'b00) ? 32'd0 : mem_word(if_pc));
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn     = 1'b0;
    br_valid   = 1'b0;
    flush      = 1'b0;
    id_allowin = 1'b1;
    mem_delay  = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_req", {31'd0, u_if.inst_req}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    @(posedge clk);
    #1;
    pop_log.delete();
    iss_log.delete();
    resetn = 1'b1;
    cyc = 0;
  endtask

  initial begin : p_main
    // Ideal port: first word two cycles after release, then one per two cycles.
    do_reset();
    @(negedge clk);
    chk("a_req0", {31'd0, u_if.inst_req}, 32'd1);
    chk("a_addr0", u_if.inst_addr, 32'hBFC0_0000);
    goto(1); @(negedge clk);
    chk("a_req1", {31'd0, u_if.inst_req}, 32'd0);
    chk("a_valid1", {31'd0, if_valid}, 32'd0);
    goto(2); @(negedge clk);
    chk("a_valid2", {31'd0, if_valid}, 32'd1);
    chk("a_pc2", if_pc, 32'hBFC0_0000);
    chk("a_addr2", u_if.inst_addr, 32'hBFC0_0004);
    goto(9); @(negedge clk); #1;
    chk("a_npop", 32'(pop_log.size()), 32'd4);
    chk("a_pop1", at(pop_log, 1), 32'hBFC0_0004);
    chk("a_pop3", at(pop_log, 3), 32'hBFC0_000C);

    // Decode stall: queue fills, requests stop, head holds.
    do_reset();
    id_allowin = 1'b0;
    goto(5); @(negedge clk);
    chk("b_req_full", {31'd0, u_if.inst_req}, 32'd0);
    chk("b_head", if_pc, 32'hBFC0_0000);
    goto(6);
    id_allowin = 1'b1;
    @(negedge clk);
    chk("b_head6", if_pc, 32'hBFC0_0000);
    goto(12); @(negedge clk); #1;
    chk("b_npop", 32'(pop_log.size()), 32'd4);
    chk("b_pop1", at(pop_log, 1), 32'hBFC0_0004);
    chk("b_pop2", at(pop_log, 2), 32'hBFC0_0008);
    chk("b_pop3", at(pop_log, 3), 32'hBFC0_000C);

    // Branch while the delay slot is in flight.
    do_reset();
    goto(7);
    br_valid = 1'b1; br_pc = 32'hBFC0_0008; br_target = 32'hBFC0_0100;
    goto(8);
    br_valid = 1'b0;
    @(negedge clk);
    chk("c_addr8", u_if.inst_addr, 32'hBFC0_0100);
    chk("c_head8", if_pc, 32'hBFC0_000C);
    goto(13); @(negedge clk); #1;
    chk("c_npop", 32'(pop_log.size()), 32'd6);
    chk("c_pop3", at(pop_log, 3), 32'hBFC0_000C);
    chk("c_pop4", at(pop_log, 4), 32'hBFC0_0100);
    chk("c_pop5", at(pop_log, 5), 32'hBFC0_0104);
    chk("c_no10", 32'(count_in(iss_log, 32'hBFC0_0010) + count_in(pop_log, 32'hBFC0_0010)), 32'd0);

    // Branch before the delay slot has been requested.
    do_reset();
    goto(5);
    br_valid = 1'b1; br_pc = 32'hBFC0_0008; br_target = 32'hBFC0_0100;
    goto(6);
    br_valid = 1'b0;
    @(negedge clk);
    chk("d_addr6", u_if.inst_addr, 32'hBFC0_000C);
    goto(8); @(negedge clk);
    chk("d_addr8", u_if.inst_addr, 32'hBFC0_0100);
    goto(11); @(negedge clk); #1;
    chk("d_npop", 32'(pop_log.size()), 32'd5);
    chk("d_pop3", at(pop_log, 3), 32'hBFC0_000C);
    chk("d_pop4", at(pop_log, 4), 32'hBFC0_0100);

    // Flush with a slow response still outstanding.
    do_reset();
    mem_delay = 3;
    goto(1);
    flush = 1'b1; flush_target = 32'hBFC0_0380;
    goto(2);
    flush = 1'b0; mem_delay = 1;
    @(negedge clk);
    chk("e_valid2", {31'd0, if_valid}, 32'd0);
    chk("e_req2", {31'd0, u_if.inst_req}, 32'd0);
    goto(3); @(negedge clk);
    chk("e_req3", {31'd0, u_if.inst_req}, 32'd0);
    goto(4); @(negedge clk);
    chk("e_req4", {31'd0, u_if.inst_req}, 32'd1);
    chk("e_addr4", u_if.inst_addr, 32'hBFC0_0380);
    chk("e_valid4", {31'd0, if_valid}, 32'd0);
    goto(7); @(negedge clk); #1;
    chk("e_npop", 32'(pop_log.size()), 32'd1);
    chk("e_pop0", at(pop_log, 0), 32'hBFC0_0380);

    // Flush and branch together on a full queue: flush wins.
    do_reset();
    id_allowin = 1'b0;
    goto(4); @(negedge clk);
    chk("f_valid4", {31'd0, if_valid}, 32'd1);
    goto(5);
    flush = 1'b1; flush_target = 32'hBFC0_0380;
    br_valid = 1'b1; br_pc = 32'hBFC0_0000; br_target = 32'hBFC0_0200;
    goto(6);
    flush = 1'b0; br_valid = 1'b0; id_allowin = 1'b1;
    @(negedge clk);
    chk("f_valid6", {31'd0, if_valid}, 32'd0);
    chk("f_addr6", u_if.inst_addr, 32'hBFC0_0380);
    goto(11); @(negedge clk); #1;
    chk("f_npop", 32'(pop_log.size()), 32'd2);
    chk("f_pop0", at(pop_log, 0), 32'hBFC0_0380);
    chk("f_pop1", at(pop_log, 1), 32'hBFC0_0384);
    chk("f_no200", 32'(count_in(iss_log, 32'hBFC0_0200)), 32'd0);

    // PC wraps modulo 2^32.
    do_reset();
    goto(1);
    flush = 1'b1; flush_target = 32'hFFFF_FFFC;
    goto(2);
    flush = 1'b0;
    @(negedge clk);
    chk("g_addr2", u_if.inst_addr, 32'hFFFF_FFFC);
    goto(4); @(negedge clk);
    chk("g_head4", if_pc, 32'hFFFF_FFFC);
    chk("g_addr4", u_if.inst_addr, 32'h0000_0000);
    chk("g_req4", {31'd0, u_if.inst_req}, 32'd1);

    // Misaligned target: error entry, then no further fetches.
    do_reset();
    id_allowin = 1'b0;
    goto(1);
    flush = 1'b1; flush_target = 32'hBFC0_0382;
    goto(2);
    flush = 1'b0;
    @(negedge clk);
    chk("h_req2", {31'd0, u_if.inst_req}, 32'd0);
    goto(3); @(negedge clk);
    chk("h_valid3", {31'd0, if_valid}, 32'd1);
    chk("h_pc3", if_pc, 32'hBFC0_0382);
    chk("h_inst3", if_inst, 32'd0);
    goto(5); @(negedge clk);
    chk("h_req5", {31'd0, u_if.inst_req}, 32'd0);
    chk("h_pc5", if_pc, 32'hBFC0_0382);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
